conv_sequencer: RTL and testbench

- Control FSM that sequences the project-1 convolution datapath.
- Fetches kernel dimensions/weights once, then walks each input matrix in SRAM: stores row/col counts, primes the 3-row window, scans columns, drains the adder pipeline and commits each output row.
- Repeats per matrix until the end-of-data marker; frames the whole run with the dut_run/dut_busy handshake.
- Sits beside the datapath and drives every one of its control strobes.

---
 rtl/conv_sequencer_if.sv | 60 ++++++
 rtl/conv_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sequencer_if.sv
// Control/handshake bundle between conv_sequencer (master) and the
// convolution datapath (slave). Optional perf outputs exist only when
// CONV_SEQ_PERF_EN is defined.
interface conv_sequencer_if;
  logic        dut_run;
  logic [15:0] sram_dut_read_data;
  logic        last_col_next;
  logic        last_row_flag;

  logic        dut_busy_toggle;
  logic        set_initialization_flag;
  logic        reset_initialization_flag;
  logic        rst_dut_wmem_read_address;
  logic        str_weights_dims;
  logic        str_weights_data;
  logic        str_input_nrows;
  logic        str_input_ncols;
  logic        incr_raddr_enable;
  logic        pln_input_row_enable;
  logic        incr_col_enable;
  logic        rst_col_counter;
  logic        incr_row_enable;
  logic        rst_row_counter;
  logic        update_d_in;
  logic        toggle_conv_go_flag;
  logic        str_temp_to_write;
  logic        rst_output_row_temp;
  logic        incr_output_addr;
  logic [3:0]  state_dbg;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [7:0]  perf_matrices;
`endif

  modport master (
`ifdef CONV_SEQ_PERF_EN
    output perf_cycles, perf_matrices,
`endif
    input  dut_run, sram_dut_read_data, last_col_next, last_row_flag,
    output dut_busy_toggle, set_initialization_flag, reset_initialization_flag,
           rst_dut_wmem_read_address, str_weights_dims, str_weights_data,
           str_input_nrows, str_input_ncols, incr_raddr_enable,
           pln_input_row_enable, incr_col_enable, rst_col_counter,
           incr_row_enable, rst_row_counter, update_d_in, toggle_conv_go_flag,
           str_temp_to_write, rst_output_row_temp, incr_output_addr, state_dbg
  );

  modport slave (
`ifdef CONV_SEQ_PERF_EN
    input  perf_cycles, perf_matrices,
`endif
    output dut_run, sram_dut_read_data, last_col_next, last_row_flag,
    input  dut_busy_toggle, set_initialization_flag, reset_initialization_flag,
           rst_dut_wmem_read_address, str_weights_dims, str_weights_data,
           str_input_nrows, str_input_ncols, incr_raddr_enable,
           pln_input_row_enable, incr_col_enable, rst_col_counter,
           incr_row_enable, rst_row_counter, update_d_in, toggle_conv_go_flag,
           str_temp_to_write, rst_output_row_temp, incr_output_addr, state_dbg
  );
endinterface

// File: rtl/conv_sequencer.sv
// Control FSM sequencing the convolution datapath: weight fetch, then per
// matrix header read, 3-row window priming, column scan, pipeline drain and
// output-row commit, until the END_MARKER row-count word.
// Every strobe is a registered Moore output: the value driven in a cycle is
// the action of the state/step held in that cycle.
// Optional: define CONV_SEQ_PERF_EN to add perf_cycles / perf_matrices.
module conv_sequencer #(
  parameter logic [15:0] END_MARKER = 16'h00FF,
  parameter int          PIPE_DEPTH = 3,
  parameter int          KROWS      = 3
) (
  input  logic             clk,
  input  logic             reset,
  conv_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, WGT = 4'd1, HDR = 4'd2, NCOL = 4'd3, PRIME = 4'd4,
    SCAN = 4'd5, DRAIN = 4'd6, COMMIT = 4'd7, DONE = 4'd8
  } state_t;

  localparam logic [7:0] KLAST = 8'(KROWS - 1);
  localparam logic [7:0] KROW  = 8'(KROWS);
  localparam logic [7:0] DLAST = 8'(PIPE_DEPTH - 1);

  state_t     state;
  logic [7:0] step;   // sub-cycle within the current state

  assign bus.state_dbg = state;

  // Sequencer: next state and next-cycle strobes, all strobes default low
  always_ff @(posedge clk) begin
    bus.dut_busy_toggle           <= 1'b0;
    bus.set_initialization_flag   <= 1'b0;
    bus.reset_initialization_flag <= 1'b0;
    bus.str_weights_dims          <= 1'b0;
    bus.str_weights_data          <= 1'b0;
    bus.str_input_nrows           <= 1'b0;
    bus.str_input_ncols           <= 1'b0;
    bus.incr_raddr_enable         <= 1'b0;
    bus.pln_input_row_enable      <= 1'b0;
    bus.incr_col_enable           <= 1'b0;
    bus.rst_col_counter           <= 1'b0;
    bus.incr_row_enable           <= 1'b0;
    bus.rst_row_counter           <= 1'b0;
    bus.update_d_in               <= 1'b0;
    bus.toggle_conv_go_flag       <= 1'b0;
    bus.str_temp_to_write         <= 1'b0;
    bus.rst_output_row_temp       <= 1'b0;
    bus.incr_output_addr          <= 1'b0;
    if (reset) begin
      state                         <= IDLE;
      step                          <= '0;
      bus.rst_dut_wmem_read_address <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.dut_run) begin
          state                         <= WGT;
          step                          <= '0;
          bus.dut_busy_toggle           <= 1'b1;
          bus.rst_dut_wmem_read_address <= 1'b0;
        end
        // step 0 = busy toggle cycle, 1 = dims, 2 = data (addr 1 selected)
        WGT: begin
          step <= step + 8'd1;
          case (step)
            8'd0: bus.str_weights_dims <= 1'b1;
            8'd1: begin
              bus.rst_dut_wmem_read_address <= 1'b1;
              bus.str_weights_data          <= 1'b1;
            end
            default: begin
              state                       <= HDR;
              step                        <= '0;
              bus.set_initialization_flag <= 1'b1;
            end
          endcase
        end
        // step 0 waits for the row-count word, step 1 captures it
        HDR: begin
          if (step == 8'd0) begin
            if (bus.sram_dut_read_data == END_MARKER) begin
              state                         <= DONE;
              bus.dut_busy_toggle           <= 1'b1;
              bus.reset_initialization_flag <= 1'b1;
            end else begin
              step                  <= 8'd1;
              bus.str_input_nrows   <= 1'b1;
              bus.incr_raddr_enable <= 1'b1;
              bus.rst_row_counter   <= 1'b1;
            end
          end else begin
            state                 <= NCOL;
            step                  <= '0;
            bus.str_input_ncols   <= 1'b1;
            bus.incr_raddr_enable <= 1'b1;
          end
        end
        NCOL: begin
          state                    <= PRIME;
          step                     <= '0;
          bus.pln_input_row_enable <= 1'b1;
          bus.incr_raddr_enable    <= 1'b1;
          bus.incr_row_enable      <= 1'b1;
        end
        // steps 0..KROWS-1 load rows, step KROWS clears the output row
        PRIME: begin
          if (step < KLAST) begin
            step                     <= step + 8'd1;
            bus.pln_input_row_enable <= 1'b1;
            bus.incr_raddr_enable    <= 1'b1;
            bus.incr_row_enable      <= 1'b1;
          end else if (step == KLAST) begin
            step                    <= KROW;
            bus.rst_output_row_temp <= 1'b1;
          end else begin
            state                   <= SCAN;
            step                    <= '0;
            bus.rst_col_counter     <= 1'b1;
            bus.toggle_conv_go_flag <= 1'b1;
          end
        end
        // step 0 = entry, 1 = column walk, 2 = closing go-flag toggle
        SCAN: begin
          case (step)
            8'd0: begin
              step                 <= 8'd1;
              bus.incr_col_enable  <= 1'b1;
              bus.update_d_in      <= 1'b1;
              bus.incr_output_addr <= 1'b1;
            end
            8'd1: if (bus.last_col_next) begin
              step                    <= 8'd2;
              bus.toggle_conv_go_flag <= 1'b1;
            end else begin
              bus.incr_col_enable  <= 1'b1;
              bus.update_d_in      <= 1'b1;
              bus.incr_output_addr <= 1'b1;
            end
            default: begin
              state <= DRAIN;
              step  <= '0;
            end
          endcase
        end
        DRAIN: begin
          if (step == DLAST) begin
            state                 <= COMMIT;
            step                  <= '0;
            bus.str_temp_to_write <= 1'b1;
          end else begin
            step <= step + 8'd1;
          end
        end
        // step 0 = write, 1 = low (write fires), 2 = clear row, 3 = advance
        COMMIT: begin
          case (step)
            8'd0: step <= 8'd1;
            8'd1: begin
              step                    <= 8'd2;
              bus.rst_output_row_temp <= 1'b1;
            end
            8'd2: if (bus.last_row_flag) begin
              state <= HDR;
              step  <= '0;
            end else begin
              step                     <= 8'd3;
              bus.pln_input_row_enable <= 1'b1;
              bus.incr_raddr_enable    <= 1'b1;
              bus.incr_row_enable      <= 1'b1;
            end
            default: begin
              state                   <= SCAN;
              step                    <= '0;
              bus.rst_col_counter     <= 1'b1;
              bus.toggle_conv_go_flag <= 1'b1;
            end
          endcase
        end
        DONE: begin
          state                         <= IDLE;
          step                          <= '0;
          bus.rst_dut_wmem_read_address <= 1'b0;
        end
        default: begin
          state <= IDLE;
          step  <= '0;
        end
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  // Busy-cycle count per run and saturating count of matrices started
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.perf_cycles   <= '0;
      bus.perf_matrices <= '0;
    end else begin
      if (state == IDLE) begin
        if (bus.dut_run) bus.perf_cycles <= '0;
      end else begin
        bus.perf_cycles <= bus.perf_cycles + 32'd1;
      end
      if (state == HDR && step == 8'd1 && bus.perf_matrices != 8'hFF)
        bus.perf_matrices <= bus.perf_matrices + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: a small datapath model answers the
// sequencer, a spec-level model queues the expected non-idle strobe groups,
// and a negedge monitor pops and compares them.
module tb_conv_sequencer;
  localparam logic [3:0] S_IDLE = 4'd0, S_WGT = 4'd1, S_SCAN = 4'd5, S_DONE = 4'd8;
  localparam int B_BUSY=0, B_SETI=1, B_RINIT=2, B_DIMS=3, B_WDATA=4, B_NROWS=5,
                 B_NCOLS=6, B_RADDR=7, B_PLN=8, B_ICOL=9, B_RSTCOL=10, B_IROW=11,
                 B_RSTROW=12, B_DIN=13, B_GO=14, B_WRITE=15, B_ROWT=16, B_OADDR=17;
  localparam logic [17:0] ONE = 18'd1;
  localparam logic [17:0] V_BUSY=ONE<<B_BUSY, V_SETI=ONE<<B_SETI, V_RINIT=ONE<<B_RINIT,
    V_DIMS=ONE<<B_DIMS, V_WDATA=ONE<<B_WDATA, V_NROWS=ONE<<B_NROWS, V_NCOLS=ONE<<B_NCOLS,
    V_RADDR=ONE<<B_RADDR, V_PLN=ONE<<B_PLN, V_ICOL=ONE<<B_ICOL, V_RSTCOL=ONE<<B_RSTCOL,
    V_IROW=ONE<<B_IROW, V_RSTROW=ONE<<B_RSTROW, V_DIN=ONE<<B_DIN, V_GO=ONE<<B_GO,
    V_WRITE=ONE<<B_WRITE, V_ROWT=ONE<<B_ROWT, V_OADDR=ONE<<B_OADDR;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_sequencer_if bus();
  conv_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  // datapath model: address register, combinational SRAM read, counters
  logic [15:0] sram [0:255];
  logic [7:0]  raddr;
  logic [15:0] nrows, ncols, row_cnt, col_cnt;
  always @(posedge clk) begin
    if (reset) begin
      raddr <= '0; nrows <= '0; ncols <= '0; row_cnt <= '0; col_cnt <= '0;
    end else begin
      if (bus.incr_raddr_enable) raddr <= raddr + 8'd1;
      if (bus.str_input_nrows) nrows <= sram[raddr];
      if (bus.str_input_ncols) ncols <= sram[raddr];
      if (bus.rst_row_counter) row_cnt <= '0;
      else if (bus.incr_row_enable) row_cnt <= row_cnt + 16'd1;
      if (bus.rst_col_counter) col_cnt <= '0;
      else if (bus.incr_col_enable) col_cnt <= col_cnt + 16'd1;
    end
  end
  assign bus.sram_dut_read_data = sram[raddr];
  assign bus.last_col_next = (col_cnt == ncols - 16'd1);
  assign bus.last_row_flag = (row_cnt == nrows);

  int errors = 0, checks = 0;
  logic [17:0] exp_q[$];
  int mr[$], mc[$];
  int n_busy, n_write, n_go, n_raddr, n_wdata, n_nrows, n_pln, busy_cycles;
  logic prev_write, in_drain;
  int zc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] vec_now();
    logic [17:0] v;
    v = '0;
    v[B_BUSY] = bus.dut_busy_toggle;       v[B_SETI] = bus.set_initialization_flag;
    v[B_RINIT] = bus.reset_initialization_flag; v[B_DIMS] = bus.str_weights_dims;
    v[B_WDATA] = bus.str_weights_data;     v[B_NROWS] = bus.str_input_nrows;
    v[B_NCOLS] = bus.str_input_ncols;      v[B_RADDR] = bus.incr_raddr_enable;
    v[B_PLN] = bus.pln_input_row_enable;   v[B_ICOL] = bus.incr_col_enable;
    v[B_RSTCOL] = bus.rst_col_counter;     v[B_IROW] = bus.incr_row_enable;
    v[B_RSTROW] = bus.rst_row_counter;     v[B_DIN] = bus.update_d_in;
    v[B_GO] = bus.toggle_conv_go_flag;     v[B_WRITE] = bus.str_temp_to_write;
    v[B_ROWT] = bus.rst_output_row_temp;   v[B_OADDR] = bus.incr_output_addr;
    return v;
  endfunction

  // monitor: pops the expected queue on every cycle with any strobe high
  always @(negedge clk) begin : mon
    logic [17:0] v;
    v = vec_now();
    if (reset) begin
      prev_write = 1'b0; in_drain = 1'b0;
    end else begin
      if (bus.state_dbg != S_IDLE) busy_cycles++;
      if (prev_write) chk("low_after_write", 32'(v), 32'd0);
      if (in_drain) begin
        if (v == '0) zc++;
        else begin chk("drain_len", zc, 32'd3); in_drain = 1'b0; end
      end
      if (v == V_GO) begin in_drain = 1'b1; zc = 0; end
      if (v != '0) begin
        if (exp_q.size() == 0) chk("unexpected_strobe", 32'(v), 32'd0);
        else chk("strobe_seq", 32'(v), 32'(exp_q.pop_front()));
      end
      if (v[B_WDATA]) chk("wmem_sel_data", 32'(bus.rst_dut_wmem_read_address), 32'd1);
      if (v[B_DIMS])  chk("wmem_sel_dims", 32'(bus.rst_dut_wmem_read_address), 32'd0);
      n_busy += int'(v[B_BUSY]);   n_write += int'(v[B_WRITE]);
      n_go += int'(v[B_GO]);       n_raddr += int'(v[B_RADDR]);
      n_wdata += int'(v[B_WDATA]); n_nrows += int'(v[B_NROWS]);
      n_pln += int'(v[B_PLN]);
      prev_write = v[B_WRITE];
    end
  end

  task automatic do_reset();
    reset = 1'b1; bus.dut_run = 1'b0;
    exp_q.delete();
    n_busy = 0; n_write = 0; n_go = 0; n_raddr = 0; n_wdata = 0; n_nrows = 0;
    n_pln = 0; busy_cycles = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // SRAM image: per matrix {nrows, ncols, rows...}, then the end marker
  task automatic load_sram();
    int a;
    a = 0;
    for (int m = 0; m < mr.size(); m++) begin
      sram[a] = 16'(mr[m]); sram[a+1] = 16'(mc[m]); a += 2;
      for (int r = 0; r < mr[m]; r++) begin sram[a] = 16'($urandom_range(0, 65535)); a++; end
    end
    sram[a] = 16'h00FF;
  endtask

  // expected strobe groups of one whole run, straight from the action list
  task automatic push_run();
    exp_q.push_back(V_BUSY); exp_q.push_back(V_DIMS);
    exp_q.push_back(V_WDATA); exp_q.push_back(V_SETI);
    for (int m = 0; m < mr.size(); m++) begin
      exp_q.push_back(V_NROWS | V_RADDR | V_RSTROW);
      exp_q.push_back(V_NCOLS | V_RADDR);
      repeat (3) exp_q.push_back(V_PLN | V_RADDR | V_IROW);
      exp_q.push_back(V_ROWT);
      for (int o = 0; o < mr[m] - 2; o++) begin
        exp_q.push_back(V_RSTCOL | V_GO);
        repeat (mc[m]) exp_q.push_back(V_ICOL | V_DIN | V_OADDR);
        exp_q.push_back(V_GO); exp_q.push_back(V_WRITE); exp_q.push_back(V_ROWT);
        if (o < mr[m] - 3) exp_q.push_back(V_PLN | V_RADDR | V_IROW);
      end
    end
    exp_q.push_back(V_BUSY | V_RINIT);
  endtask

  task automatic start_run();
    @(posedge clk); #1 bus.dut_run = 1'b1;
    @(posedge clk); #1 bus.dut_run = 1'b0;
  endtask

  task automatic wait_idle(int target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #2;
      if (n_busy >= target && bus.state_dbg == S_IDLE) begin ok = 1'b1; break; end
    end
    chk("run_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run_test(string tag);
    int wr, rd, pl;
    wr = 0; rd = 0; pl = 0;
    do_reset(); load_sram(); push_run();
    for (int i = 0; i < mr.size(); i++) begin
      wr += mr[i] - 2; rd += mr[i] + 2; pl += mr[i];
    end
    start_run(); wait_idle(2);
    chk({tag, "_busy_toggles"}, n_busy, 32'd2);
    chk({tag, "_writes"}, n_write, wr);
    chk({tag, "_go_toggles"}, n_go, 2 * wr);
    chk({tag, "_raddr_incr"}, n_raddr, rd);
    chk({tag, "_row_shifts"}, n_pln, pl);
    chk({tag, "_nrows_strobes"}, n_nrows, mr.size());
    chk({tag, "_wdata_once"}, n_wdata, 32'd1);
    chk({tag, "_queue_left"}, exp_q.size(), 32'd0);
`ifdef CONV_SEQ_PERF_EN
    chk({tag, "_perf_matrices"}, 32'(bus.perf_matrices), mr.size());
    chk({tag, "_perf_cycles"}, bus.perf_cycles, busy_cycles);
`endif
  endtask

  initial begin
    logic found;
    bus.dut_run = 1'b0;
    for (int i = 0; i < 256; i++) sram[i] = 16'h0000;

    // reset state
    do_reset();
    @(posedge clk); #2;
    chk("reset_strobes", 32'(vec_now()), 32'd0);
    chk("reset_state", 32'(bus.state_dbg), 32'(S_IDLE));
    chk("reset_wmem_sel", 32'(bus.rst_dut_wmem_read_address), 32'd0);

    // directed cases
    mr = {};      mc = {};      run_test("end_only");
    mr = {3};     mc = {3};     run_test("m3x3");
    mr = {5};     mc = {5};     run_test("m5x5");
    mr = {4, 3};  mc = {4, 3};  run_test("m4x4_3x3");

    // randomized matrix lists
    for (int t = 0; t < 6; t++) begin
      int nm;
      nm = $urandom_range(1, 3);
      mr = {}; mc = {};
      for (int m = 0; m < nm; m++) begin
        mr.push_back($urandom_range(3, 7));
        mc.push_back($urandom_range(1, 6));
      end
      run_test("rand");
    end

    // dut_run held across DONE: one IDLE cycle, then a fresh run
    do_reset();
    mr = {}; mc = {};
    load_sram(); push_run(); push_run();
    @(posedge clk); #1 bus.dut_run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (bus.state_dbg == S_DONE) begin found = 1'b1; break; end
    end
    chk("held_reach_done", 32'(found), 32'd1);
    @(posedge clk); #2;
    chk("held_idle_gap", 32'(bus.state_dbg), 32'(S_IDLE));
    @(posedge clk); #2;
    chk("held_restart", 32'(bus.state_dbg), 32'(S_WGT));
    bus.dut_run = 1'b0;
    wait_idle(4);
    chk("held_busy_toggles", n_busy, 32'd4);
    chk("held_queue_left", exp_q.size(), 32'd0);

    // reset in the middle of a column scan
    do_reset();
    mr = {5}; mc = {4};
    load_sram(); push_run(); start_run();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (bus.state_dbg == S_SCAN) begin found = 1'b1; break; end
    end
    chk("mid_reach_scan", 32'(found), 32'd1);
    reset = 1'b1; exp_q.delete();
    @(posedge clk); #2;
    chk("mid_rst_strobes", 32'(vec_now()), 32'd0);
    chk("mid_rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
    @(posedge clk); #2;
    chk("mid_rst_strobes2", 32'(vec_now()), 32'd0);
    #1 reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #2;
      chk("mid_post_idle", 32'(bus.state_dbg), 32'(S_IDLE));
    end
    chk("mid_no_busy_toggle", n_busy, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
